// File: rtl/alu16_pkg.sv
// alu16 shared constants and flag bundle.
// Optional subtract mode: define ALU16_SUB_EN.
package alu16_pkg;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;

   typedef struct packed {
      logic sign;
      logic zero;
      logic carry;
      logic parity;
      logic overflow;
   } flags_t;

endpackage

// File: rtl/add4_slice.sv
// Ripple adder slice with carry in/out.
// Chained by alu16 to build the full-width sum.
module add4_slice #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b}
               + {{N{1'b0}}, cin};
   assign s    = sum[N-1:0];
   assign cout = sum[N];

endmodule

// File: rtl/alu16.sv
// Registered adder with sign/zero/carry/parity/overflow flags.
// Define ALU16_SUB_EN to add a sub port (x + ~y + 1).
module alu16 #(
   parameter int WIDTH = alu16_pkg::WIDTH,
   parameter int SLICE = alu16_pkg::SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
`ifdef ALU16_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] z,
   output logic             sign,
   output logic             zero,
   output logic             carry,
   output logic             parity,
   output logic             overflow
);

   import alu16_pkg::*;

   localparam int NS = WIDTH / SLICE;

   logic [NS:0]      c;
   logic [WIDTH-1:0] yb;
   logic [WIDTH-1:0] s;
   flags_t           fn;
   flags_t           fq;
   logic [WIDTH-1:0] zq;
   logic             vq;

`ifdef ALU16_SUB_EN
   assign yb   = sub ? ~y : y;
   assign c[0] = sub;
`else
   assign yb   = y;
   assign c[0] = 1'b0;
`endif

   genvar i;
   for (i = 0; i < NS; i++) begin : g_sl
      add4_slice #(
         .N    (SLICE)
      ) u_sl (
         .a    (x[i*SLICE +: SLICE]),
         .b    (yb[i*SLICE +: SLICE]),
         .cin  (c[i]),
         .s    (s[i*SLICE +: SLICE]),
         .cout (c[i+1])
      );
   end

   // overflow sees the effective (possibly inverted) y operand
   always_comb begin
      fn          = '0;
      fn.sign     = s[WIDTH-1];
      fn.zero     = (s == '0);
      fn.carry    = c[NS];
      fn.parity   = ~^s;
      fn.overflow =
         (x[WIDTH-1] & yb[WIDTH-1] & ~s[WIDTH-1]) |
         (~x[WIDTH-1] & ~yb[WIDTH-1] & s[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vq <= 1'b0;
         zq <= '0;
         fq <= '0;
      end else begin
         vq <= in_valid;
         if (in_valid) begin
            zq <= s;
            fq <= fn;
         end
      end
   end

   assign out_valid = vq;
   assign z         = zq;
   assign sign      = fq.sign;
   assign zero      = fq.zero;
   assign carry     = fq.carry;
   assign parity    = fq.parity;
   assign overflow  = fq.overflow;

endmodule

// File: tb/tb_alu16.sv
// Scoreboard bench for alu16: driver queues expected
// {z,sign,zero,carry,parity,overflow}, monitor pops on out_valid.
module tb_alu16;

   import alu16_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic        out_valid;
   logic [15:0] z;
   logic        sign, zero, carry;
   logic        parity, overflow;

   int checks = 0;
   int failures = 0;
   logic [20:0] q[$];

   alu16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .x         (x),
      .y         (y),
`ifdef ALU16_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .z         (z),
      .sign      (sign),
      .zero      (zero),
      .carry     (carry),
      .parity    (parity),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n,
                      input logic [20:0] act,
                      input logic [20:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, act, exp);
      end
   endtask

   function automatic logic [20:0] outs();
      return {z, sign, zero, carry, parity, overflow};
   endfunction

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (q.size() == 0)
            chk("spurious_valid", 21'd1, 21'd0);
         else
            chk("result", outs(), q.pop_front());
      end
   end

   task automatic drive(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic        s,
                        input logic [20:0] e);
      @(negedge clk);
      x = a;
      y = b;
      sub = s;
      in_valid = 1'b1;
      q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      sub = 1'b0;
   endtask

   localparam logic [20:0] E1 = {16'h0FFF, 5'b00111};
   localparam logic [20:0] E2 = {16'h0000, 5'b01110};
   localparam logic [20:0] E3 = {16'hFFFF, 5'b10010};
   localparam logic [20:0] E4 = {16'h0001, 5'b00000};

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b1;
      x = 16'hFFFF;
      y = 16'h0001;
      repeat (2) @(negedge clk);
      chk("reset_outs", outs(), 21'd0);
      chk("reset_valid", {20'd0, out_valid}, 21'd0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_reset_outs", outs(), 21'd0);
      chk("post_reset_valid", {20'd0, out_valid}, 21'd0);

      drive(16'h8FFF, 16'h8000, 1'b0, E1);
      idle();
      @(negedge clk);
      chk("hold_valid", {20'd0, out_valid}, 21'd0);
      chk("hold_outs", outs(), E1);
      drive(16'hFFFE, 16'h0002, 1'b0, E2);
      idle();
      drive(16'hAAAA, 16'h5555, 1'b0, E3);
      idle();
      @(negedge clk);
      chk("hold_outs3", outs(), E3);

      drive(16'h8FFF, 16'h8000, 1'b0, E1);
      drive(16'hFFFE, 16'h0002, 1'b0, E2);
      chk("b2b_valid1", {20'd0, out_valid}, 21'd1);
      drive(16'hAAAA, 16'h5555, 1'b0, E3);
      chk("b2b_valid2", {20'd0, out_valid}, 21'd1);
      idle();
      chk("b2b_valid3", {20'd0, out_valid}, 21'd1);
      @(negedge clk);
      chk("b2b_end", {20'd0, out_valid}, 21'd0);

      drive(16'h0001, 16'h0000, 1'b0, E4);
      idle();
      chk("pulse_on", {20'd0, out_valid}, 21'd1);
      @(negedge clk);
      chk("pulse_off", {20'd0, out_valid}, 21'd0);

`ifdef ALU16_SUB_EN
      drive(16'h0005, 16'h0007, 1'b1,
            {16'hFFFE, 5'b10000});
      drive(16'h8000, 16'h0001, 1'b1,
            {16'h7FFF, 5'b00101});
      drive(16'h0005, 16'h0007, 1'b0,
            {16'h000C, 5'b00010});
      idle();
      @(negedge clk);
`endif

      @(negedge clk);
      x = 16'h1234;
      y = 16'h0001;
      in_valid = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      chk("midrst_valid", {20'd0, out_valid}, 21'd0);
      chk("midrst_outs", outs(), 21'd0);

      repeat (2) @(negedge clk);
      chk("queue_empty", 21'(q.size()), 21'd0);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
